// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV64 core, with optional load-use hazard
// detection enabled by defining ID_EX_HAZARD_DETECT_EN.
module id_ex_stage #(
    parameter int XLEN     = 64,
    parameter int REG_W    = 5,
    parameter int ALU_OP_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic                id_alusrc,
    input  logic                id_memtoreg,
    input  logic                id_regwrite,
    input  logic                id_memread,
    input  logic                id_memwrite,
    input  logic                id_branch,
    input  logic [ALU_OP_W-1:0] id_aluop,
    input  logic [XLEN-1:0]     id_rs1_data,
    input  logic [XLEN-1:0]     id_rs2_data,
    input  logic [XLEN-1:0]     id_imm,
    input  logic [XLEN-1:0]     id_pc,
    input  logic [REG_W-1:0]    id_rs1,
    input  logic [REG_W-1:0]    id_rs2,
    input  logic [REG_W-1:0]    id_rd,
    input  logic [3:0]          id_funct,
    input  logic                flush,
    output logic                ex_valid,
    output logic                ex_alusrc,
    output logic                ex_memtoreg,
    output logic                ex_regwrite,
    output logic                ex_memread,
    output logic                ex_memwrite,
    output logic                ex_branch,
    output logic [ALU_OP_W-1:0] ex_aluop,
    output logic [XLEN-1:0]     ex_rs1_data,
    output logic [XLEN-1:0]     ex_rs2_data,
    output logic [XLEN-1:0]     ex_imm,
    output logic [XLEN-1:0]     ex_pc,
    output logic [REG_W-1:0]    ex_rs1,
    output logic [REG_W-1:0]    ex_rs2,
    output logic [REG_W-1:0]    ex_rd,
    output logic [3:0]          ex_funct,
    output logic                stall
);

    logic haz;
    logic bub;

`ifdef ID_EX_HAZARD_DETECT_EN
    // Both rs fields are compared for every format; a spurious match only costs a bubble.
    assign haz = ex_valid & ex_memread & (ex_rd != '0)
               & ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & id_valid;
`else
    assign haz = 1'b0;
`endif

    // A flush wins over a hazard so the fetch redirect is not held off.
    assign stall = haz & ~flush;
    assign bub   = flush | haz | ~id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_aluop    <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
        end else begin
            // Only valid and control are squashed; the datapath fields load unconditionally.
            ex_valid    <= ~bub;
            ex_alusrc   <= id_alusrc   & ~bub;
            ex_memtoreg <= id_memtoreg & ~bub;
            ex_regwrite <= id_regwrite & ~bub;
            ex_memread  <= id_memread  & ~bub;
            ex_memwrite <= id_memwrite & ~bub;
            ex_branch   <= id_branch   & ~bub;
            ex_aluop    <= bub ? '0 : id_aluop;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_pc       <= id_pc;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues expected EX contents,
// a monitor pops and compares them one cycle later.
module tb_id_ex_stage;

`ifdef ID_EX_HAZARD_DETECT_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    // {alusrc, memtoreg, regwrite, memread, memwrite, branch}
    localparam logic [5:0] C_R  = 6'b001000;
    localparam logic [5:0] C_LD = 6'b111100;
    localparam logic [5:0] C_ST = 6'b100010;
    localparam logic [2:0] OP_R = 3'b010;
    localparam logic [2:0] OP_M = 3'b000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_alusrc = 1'b0, id_memtoreg = 1'b0, id_regwrite = 1'b0;
    logic        id_memread = 1'b0, id_memwrite = 1'b0, id_branch = 1'b0;
    logic [2:0]  id_aluop = '0;
    logic [63:0] id_rs1_data = '0, id_rs2_data = '0, id_imm = '0, id_pc = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [3:0]  id_funct = '0;
    logic        flush = 1'b0;
    logic        ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite;
    logic        ex_memread, ex_memwrite, ex_branch;
    logic [2:0]  ex_aluop;
    logic [63:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
    logic        stall;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
        .id_aluop(id_aluop), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_funct(id_funct), .flush(flush),
        .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_aluop(ex_aluop), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [5:0]  ctrl;
        logic [2:0]  aluop;
        logic [255:0] data;
        logic [14:0] idx;
        logic [3:0]  funct;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [255:0] all_ex();
        return {ex_rs1_data, ex_rs2_data, ex_imm, ex_pc} | 256'({ex_valid, ex_alusrc,
                ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_aluop,
                ex_rs1, ex_rs2, ex_rd, ex_funct});
    endfunction

    // Drive one ID instruction after the falling edge, check stall, queue the EX image.
    task automatic apply(input string name, input bit v, input logic [5:0] c,
                         input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input bit fl, input bit e_stall,
                         input bit e_valid);
        exp_t e;
        @(negedge clk);
        id_valid = v;
        {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch} = c;
        id_aluop = op;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_rs1_data = {$urandom, $urandom};
        id_rs2_data = {$urandom, $urandom};
        id_imm      = {$urandom, $urandom};
        id_pc       = {$urandom, $urandom};
        id_funct    = 4'($urandom_range(15));
        flush = fl;
        #1;
        chk({name, ".stall"}, 256'(stall), 256'(e_stall));
        e.name  = name;
        e.valid = e_valid;
        e.ctrl  = e_valid ? c : 6'b0;
        e.aluop = e_valid ? op : 3'b0;
        e.data  = {id_rs1_data, id_rs2_data, id_imm, id_pc};
        e.idx   = {r1, r2, rd};
        e.funct = id_funct;
        exp_q.push_back(e);
        $display("vec %s: valid=%0d flush=%0d rs1=%0d rs2=%0d rd=%0d stall=%0d",
                 name, v, fl, r1, r2, rd, stall);
    endtask

    // Monitor: each EX image the driver queued is compared right after its capture edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".valid"}, 256'(ex_valid), 256'(e.valid));
                chk({e.name, ".ctrl"}, 256'({ex_alusrc, ex_memtoreg, ex_regwrite,
                    ex_memread, ex_memwrite, ex_branch}), 256'(e.ctrl));
                chk({e.name, ".aluop"}, 256'(ex_aluop), 256'(e.aluop));
                chk({e.name, ".data"}, {ex_rs1_data, ex_rs2_data, ex_imm, ex_pc}, e.data);
                chk({e.name, ".idx"}, 256'({ex_rs1, ex_rs2, ex_rd}), 256'(e.idx));
                chk({e.name, ".funct"}, 256'(ex_funct), 256'(e.funct));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("reset.outputs", all_ex(), 256'd0);
        chk("reset.stall", 256'(stall), 256'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        apply("add_x3",      1, C_R,  OP_R, 1, 2, 3,  0, 0, 1);
        apply("ld_x5",       1, C_LD, OP_M, 1, 0, 5,  0, 0, 1);
        apply("add_x6_haz",  1, C_R,  OP_R, 5, 2, 6,  0, HZ, !HZ);
        apply("add_x6_rep",  1, C_R,  OP_R, 5, 2, 6,  0, 0, 1);
        apply("ld_x0",       1, C_LD, OP_M, 1, 0, 0,  0, 0, 1);
        apply("add_x0x0",    1, C_R,  OP_R, 0, 0, 6,  0, 0, 1);
        apply("ld_x7",       1, C_LD, OP_M, 2, 0, 7,  0, 0, 1);
        apply("flush_haz",   1, C_R,  OP_R, 1, 7, 8,  1, 0, 0);
        apply("add_x8",      1, C_R,  OP_R, 1, 7, 8,  0, 0, 1);
        apply("flush_plain", 1, C_R,  OP_R, 1, 2, 9,  1, 0, 0);
        apply("id_invalid",  0, C_LD, OP_R, 1, 2, 9,  0, 0, 0);
        apply("ld_x9",       1, C_LD, OP_M, 1, 0, 9,  0, 0, 1);
        apply("sd_rs2_haz",  1, C_ST, OP_M, 2, 9, 0,  0, HZ, !HZ);
        apply("sd_rep",      1, C_ST, OP_M, 2, 9, 0,  0, 0, 1);
        apply("ld_x10",      1, C_LD, OP_M, 1, 0, 10, 0, 0, 1);
        apply("ld_x11_haz",  1, C_LD, OP_M, 10, 0, 11, 0, HZ, !HZ);
        if (HZ) apply("ld_x11_rep", 1, C_LD, OP_M, 10, 0, 11, 0, 0, 1);
        apply("ld_x12_haz",  1, C_LD, OP_M, 11, 0, 12, 0, HZ, !HZ);
        if (HZ) apply("ld_x12_rep", 1, C_LD, OP_M, 11, 0, 12, 0, 0, 1);
        apply("ld_x13",      1, C_LD, OP_M, 1, 0, 13, 0, 0, 1);

        // Mid-cycle reset with a loaded instruction in EX and a stall pending.
        @(negedge clk);
        id_valid = 1'b1;
        {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch} = C_R;
        id_aluop = OP_R; id_rs1 = 5'd13; id_rs2 = 5'd2; id_rd = 5'd14; flush = 1'b0;
        #1;
        chk("pre_rst.ex_valid", 256'(ex_valid), 256'd1);
        chk("pre_rst.stall", 256'(stall), 256'(HZ));
        rst = 1'b1;
        #1;
        chk("mid_rst.outputs", all_ex(), 256'd0);
        chk("mid_rst.stall", 256'(stall), 256'd0);
        $display("vec mid_rst: ex_valid=%0d stall=%0d", ex_valid, stall);
        @(negedge clk);
        rst = 1'b0;

        apply("post_rst_add", 1, C_R, OP_R, 13, 2, 14, 0, 0, 1);
        @(posedge clk);
        #2;
        chk("queue_drained", 256'(exp_q.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
